openhmc_rf_master: RTL and testbench



---
 rtl/openhmc_rf_master.sv | 147 ++++++++++++++
 tb/tb_openhmc_rf_master.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/openhmc_rf_master.sv
// Register-file initiator for openHMC: turns single read/write commands into
// RF enable pulses, waits for completion (with timeout) and returns a response.
module openhmc_rf_master #(
    parameter int HMC_RF_AWIDTH = 4,
    parameter int HMC_RF_WWIDTH = 64,
    parameter int HMC_RF_RWIDTH = 64,
    parameter int TIMEOUT_LOG   = 8
) (
    input  logic                     clk_hmc,
    input  logic                     res_hmc,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [HMC_RF_AWIDTH-1:0] cmd_addr,
    input  logic [HMC_RF_WWIDTH-1:0] cmd_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [HMC_RF_RWIDTH-1:0] rsp_rdata,
    output logic [1:0]               rsp_status,
    output logic [HMC_RF_AWIDTH-1:0] rf_address,
    output logic                     rf_read_en,
    output logic                     rf_write_en,
    output logic [HMC_RF_WWIDTH-1:0] rf_write_data,
    input  logic [HMC_RF_RWIDTH-1:0] rf_read_data,
    input  logic                     rf_invalid_address,
    input  logic                     rf_access_complete,
    output logic                     busy,
    output logic                     err_stray
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t                   state_q;
    logic                     write_q;
    logic [TIMEOUT_LOG-1:0]   cnt_q;
    logic [TIMEOUT_LOG-1:0]   cnt_d;
    logic                     timeout_d;
    logic                     cmd_ready_q;
    logic                     rsp_valid_q;
    logic [HMC_RF_RWIDTH-1:0] rsp_rdata_q;
    logic [1:0]               rsp_status_q;
    logic [HMC_RF_AWIDTH-1:0] rf_address_q;
    logic                     rf_read_en_q;
    logic                     rf_write_en_q;
    logic [HMC_RF_WWIDTH-1:0] rf_write_data_q;
    logic                     busy_q;
    logic                     err_stray_q;
    logic [HMC_RF_RWIDTH-1:0] cap_rdata_d;
    logic [1:0]               cap_status_d;

    // Timeout fires on the WAIT cycle in which the counter reaches all-ones.
    always_comb begin
        cnt_d        = cnt_q + TIMEOUT_LOG'(1);
        timeout_d    = &cnt_d;
        cap_status_d = rf_invalid_address ? 2'b01 : 2'b00;
        cap_rdata_d  = (rf_invalid_address || write_q) ? '0 : rf_read_data;
    end

    always_ff @(posedge clk_hmc) begin
        if (res_hmc) begin
            state_q         <= ST_IDLE;
            write_q         <= 1'b0;
            cnt_q           <= '0;
            cmd_ready_q     <= 1'b1;
            rsp_valid_q     <= 1'b0;
            rsp_rdata_q     <= '0;
            rsp_status_q    <= 2'b00;
            rf_address_q    <= '0;
            rf_read_en_q    <= 1'b0;
            rf_write_en_q   <= 1'b0;
            rf_write_data_q <= '0;
            busy_q          <= 1'b0;
            err_stray_q     <= 1'b0;
        end else begin
            rf_read_en_q  <= 1'b0;
            rf_write_en_q <= 1'b0;
            if (rf_access_complete && (state_q == ST_IDLE || state_q == ST_RESP)) begin
                err_stray_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        write_q         <= cmd_write;
                        rf_address_q    <= cmd_addr;
                        rf_write_data_q <= cmd_wdata;
                        rf_write_en_q   <= cmd_write;
                        rf_read_en_q    <= !cmd_write;
                        cmd_ready_q     <= 1'b0;
                        busy_q          <= 1'b1;
                        state_q         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt_q <= '0;
                    if (rf_access_complete) begin
                        rsp_rdata_q  <= cap_rdata_d;
                        rsp_status_q <= cap_status_d;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= ST_RESP;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_d;
                    if (rf_access_complete) begin
                        rsp_rdata_q  <= cap_rdata_d;
                        rsp_status_q <= cap_status_d;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= ST_RESP;
                    end else if (timeout_d) begin
                        rsp_rdata_q  <= '0;
                        rsp_status_q <= 2'b10;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_status    = rsp_status_q;
    assign rf_address    = rf_address_q;
    assign rf_read_en    = rf_read_en_q;
    assign rf_write_en   = rf_write_en_q;
    assign rf_write_data = rf_write_data_q;
    assign busy          = busy_q;
    assign err_stray     = err_stray_q;

endmodule

// File: tb/tb_openhmc_rf_master.sv
// Bench for openhmc_rf_master: directed scenarios plus random traffic, checked
// every cycle against a transaction-level model (response queue + cycle ages).
module tb_openhmc_rf_master;

    localparam int AW     = 4;
    localparam int WW     = 64;
    localparam int RW     = 64;
    localparam int TO_LOG = 4;
    localparam int TO_AGE = 2 ** TO_LOG;

    logic          clk_hmc = 1'b0;
    logic          res_hmc;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [WW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [RW-1:0] rsp_rdata;
    logic [1:0]    rsp_status;
    logic [AW-1:0] rf_address;
    logic          rf_read_en;
    logic          rf_write_en;
    logic [WW-1:0] rf_write_data;
    logic [RW-1:0] rf_read_data;
    logic          rf_invalid_address;
    logic          rf_access_complete;
    logic          busy;
    logic          err_stray;

    openhmc_rf_master #(
        .HMC_RF_AWIDTH(AW),
        .HMC_RF_WWIDTH(WW),
        .HMC_RF_RWIDTH(RW),
        .TIMEOUT_LOG  (TO_LOG)
    ) dut (
        .clk_hmc           (clk_hmc),
        .res_hmc           (res_hmc),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_write         (cmd_write),
        .cmd_addr          (cmd_addr),
        .cmd_wdata         (cmd_wdata),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_rdata         (rsp_rdata),
        .rsp_status        (rsp_status),
        .rf_address        (rf_address),
        .rf_read_en        (rf_read_en),
        .rf_write_en       (rf_write_en),
        .rf_write_data     (rf_write_data),
        .rf_read_data      (rf_read_data),
        .rf_invalid_address(rf_invalid_address),
        .rf_access_complete(rf_access_complete),
        .busy              (busy),
        .err_stray         (err_stray)
    );

    always #5 clk_hmc = ~clk_hmc;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endfunction

    // Transaction-level model
    typedef struct {
        logic [RW-1:0] d;
        logic [1:0]    s;
    } rsp_t;

    rsp_t          m_rq[$];
    int unsigned   cyc = 0;
    bit            m_inflight = 0;
    int unsigned   m_acc = 0;
    bit            m_w = 0;
    logic [AW-1:0] m_addr = '0;
    logic [WW-1:0] m_wd = '0;
    bit            m_stray = 0;
    bit            m_rd = 0;
    bit            m_wr = 0;
    bit            m_rst_seen = 0;

    task automatic model_edge();
        rsp_t r;
        m_rst_seen = 0;
        if (res_hmc) begin
            m_inflight = 0;
            m_rq.delete();
            m_stray = 0;
            m_rd = 0;
            m_wr = 0;
            m_addr = '0;
            m_wd = '0;
            m_rst_seen = 1;
        end else begin
            m_rd = 0;
            m_wr = 0;
            if (m_inflight) begin
                if (rf_access_complete) begin
                    r.s = rf_invalid_address ? 2'b01 : 2'b00;
                    r.d = (rf_invalid_address || m_w) ? '0 : rf_read_data;
                    m_rq.push_back(r);
                    m_inflight = 0;
                end else if (cyc - m_acc == TO_AGE) begin
                    r.s = 2'b10;
                    r.d = '0;
                    m_rq.push_back(r);
                    m_inflight = 0;
                end
            end else if (m_rq.size() != 0) begin
                if (rf_access_complete) m_stray = 1;
                if (rsp_ready) void'(m_rq.pop_front());
            end else begin
                if (rf_access_complete) m_stray = 1;
                if (cmd_valid) begin
                    m_inflight = 1;
                    m_acc = cyc;
                    m_w = cmd_write;
                    m_addr = cmd_addr;
                    m_wd = cmd_wdata;
                    m_wr = cmd_write;
                    m_rd = !cmd_write;
                end
            end
        end
        cyc++;
    endtask

    task automatic model_check();
        bit busy_e;
        busy_e = m_inflight || (m_rq.size() != 0);
        chk("cmd_ready", 64'(cmd_ready), 64'(!busy_e));
        chk("busy", 64'(busy), 64'(busy_e));
        chk("rsp_valid", 64'(rsp_valid), 64'(m_rq.size() != 0));
        chk("rf_read_en", 64'(rf_read_en), 64'(m_rd));
        chk("rf_write_en", 64'(rf_write_en), 64'(m_wr));
        chk("err_stray", 64'(err_stray), 64'(m_stray));
        if (m_rq.size() != 0) begin
            chk("rsp_rdata", 64'(rsp_rdata), 64'(m_rq[0].d));
            chk("rsp_status", 64'(rsp_status), 64'(m_rq[0].s));
        end
        if (m_rst_seen) begin
            chk("rsp_rdata_rst", 64'(rsp_rdata), 64'd0);
            chk("rsp_status_rst", 64'(rsp_status), 64'd0);
        end
        if (busy_e || m_rst_seen) begin
            chk("rf_address", 64'(rf_address), 64'(m_addr));
            chk("rf_write_data", 64'(rf_write_data), 64'(m_wd));
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk_hmc);
        #1;
        model_check();
    endtask

    task automatic quiet();
        res_hmc = 0;
        cmd_valid = 0;
        cmd_write = 0;
        cmd_addr = '0;
        cmd_wdata = '0;
        rsp_ready = 0;
        rf_read_data = '0;
        rf_invalid_address = 0;
        rf_access_complete = 0;
    endtask

    task automatic issue(input bit w, input logic [AW-1:0] a, input logic [WW-1:0] d);
        cmd_valid = 1;
        cmd_write = w;
        cmd_addr = a;
        cmd_wdata = d;
        step();
        cmd_valid = 0;
    endtask

    initial begin
        quiet();
        res_hmc = 1;
        step();
        chk("reset_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("reset_busy", 64'(busy), 64'd0);
        res_hmc = 0;
        step();

        // Write, completion two cycles after acceptance
        issue(1, 4'h3, 64'hDEAD_BEEF);
        chk("t1_wr_pulse", 64'(rf_write_en), 64'd1);
        chk("t1_rd_idle", 64'(rf_read_en), 64'd0);
        step();
        chk("t1_wr_once", 64'(rf_write_en), 64'd0);
        rf_access_complete = 1;
        step();
        rf_access_complete = 0;
        chk("t1_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("t1_status", 64'(rsp_status), 64'd0);
        chk("t1_rdata", 64'(rsp_rdata), 64'd0);
        rsp_ready = 1;
        step();
        chk("t1_ready_back", 64'(cmd_ready), 64'd1);
        rsp_ready = 0;

        // Read, completion at t+5
        issue(0, 4'h7, 64'h5555);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t2_addr_hold", 64'(rf_address), 64'h7);
        end
        rf_access_complete = 1;
        rf_read_data = 64'h0123_4567_89AB_CDEF;
        step();
        rf_access_complete = 0;
        rf_read_data = '0;
        chk("t2_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("t2_rdata", 64'(rsp_rdata), 64'h0123_4567_89AB_CDEF);
        step();
        chk("t2_addr_resp", 64'(rf_address), 64'h7);
        rsp_ready = 1;
        step();
        rsp_ready = 0;

        // Invalid address read
        issue(0, 4'h9, '0);
        rf_access_complete = 1;
        rf_invalid_address = 1;
        rf_read_data = 64'hFFFF_0000_FFFF_0000;
        step();
        quiet();
        chk("t3_status", 64'(rsp_status), 64'd1);
        chk("t3_rdata", 64'(rsp_rdata), 64'd0);
        rsp_ready = 1;
        step();
        rsp_ready = 0;

        // Timeout, then a late completion
        issue(0, 4'h2, '0);
        for (int k = 1; k <= 15; k++) begin
            step();
            chk("t4_no_rsp", 64'(rsp_valid), 64'd0);
        end
        step();
        chk("t4_rsp_t17", 64'(rsp_valid), 64'd1);
        chk("t4_status", 64'(rsp_status), 64'd2);
        for (int k = 0; k < 3; k++) step();
        rf_access_complete = 1;
        step();
        rf_access_complete = 0;
        chk("t4_stray", 64'(err_stray), 64'd1);
        chk("t4_same_rsp", 64'(rsp_status), 64'd2);
        rsp_ready = 1;
        step();
        rsp_ready = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t4_no_second", 64'(rsp_valid), 64'd0);
        end

        // Response back-pressure with a pending command
        issue(0, 4'hA, '0);
        rf_access_complete = 1;
        rf_read_data = 64'hA5A5_1234_0000_9999;
        step();
        quiet();
        cmd_valid = 1;
        cmd_write = 1;
        cmd_addr = 4'h5;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("t5_hold_rdata", 64'(rsp_rdata), 64'hA5A5_1234_0000_9999);
            chk("t5_no_accept", 64'(cmd_ready), 64'd0);
        end
        rsp_ready = 1;
        step();
        chk("t5_ready_back", 64'(cmd_ready), 64'd1);
        quiet();
        step();
        step();
        rf_access_complete = 1;
        step();
        quiet();
        rsp_ready = 1;
        step();
        rsp_ready = 0;

        // Reset during WAIT
        issue(0, 4'hC, 64'h77);
        step();
        step();
        res_hmc = 1;
        step();
        res_hmc = 0;
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_ready", 64'(cmd_ready), 64'd1);
        chk("t6_addr", 64'(rf_address), 64'd0);
        chk("t6_stray", 64'(err_stray), 64'd0);
        step();
        chk("t6_no_pulse", 64'(rf_read_en), 64'd0);
        issue(1, 4'h1, 64'h1111);
        chk("t6_wr_pulse", 64'(rf_write_en), 64'd1);
        rf_access_complete = 1;
        step();
        rf_access_complete = 0;
        chk("t6_rsp", 64'(rsp_valid), 64'd1);
        rsp_ready = 1;
        step();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            res_hmc            = ($urandom_range(0, 399) == 0);
            cmd_valid          = $urandom_range(0, 1);
            cmd_write          = $urandom_range(0, 1);
            cmd_addr           = AW'($urandom);
            cmd_wdata          = {$urandom, $urandom};
            rsp_ready          = ($urandom_range(0, 3) != 0);
            rf_access_complete = ($urandom_range(0, 9) == 0);
            rf_invalid_address = ($urandom_range(0, 4) == 0);
            rf_read_data       = {$urandom, $urandom};
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
